// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator with a tick-driven pixel pipeline that
// realigns memory read data with sync, plus built-in test patterns and markers.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int PIX_DIV  = 1,
    parameter int RD_LAT   = 0,
    parameter int CNT_W    = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [23:0]      solid_rgb,
    output logic [CNT_W-1:0] h_addr,
    output logic [CNT_W-1:0] v_addr,
    output logic             addr_valid,
    input  logic [23:0]      pix_data,
    output logic             hsync,
    output logic             vsync,
    output logic             valid,
    output logic [7:0]       vga_r,
    output logic [7:0]       vga_g,
    output logic [7:0]       vga_b,
    output logic             frame_start,
    output logic             line_start
);

    localparam int H_TOT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_BEG = H_ACTIVE + H_FP;
    localparam int HS_END = HS_BEG + H_SYNC;
    localparam int VS_BEG = V_ACTIVE + V_FP;
    localparam int VS_END = VS_BEG + V_SYNC;
    localparam int DIV_W  = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam int BAR_W  = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOT - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOT - 1);
    localparam logic             HS_ON    = 1'(HS_POL);
    localparam logic             VS_ON    = 1'(VS_POL);

    typedef struct packed {
        logic             act;
        logic             hs;
        logic             vs;
        logic             first_pix;
        logic             first_line;
        logic [1:0]       mode;
        logic [CNT_W-1:0] h;
        logic [CNT_W-1:0] v;
    } stage_t;

    logic [DIV_W-1:0] div;
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic [1:0]       mode_q;
    logic             tick;
    logic             h_act;
    logic             v_act;
    stage_t           head;
    stage_t           tail;
    stage_t           pipe [RD_LAT+1];
    logic [CNT_W-1:0] bar_q;
    logic [2:0]       bar_idx;
    logic [23:0]      pix_rgb;

    assign tick = en && (div == DIV_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            div    <= '0;
            h_cnt  <= '0;
            v_cnt  <= '0;
            mode_q <= '0;
        end else if (en) begin
            div <= (div == DIV_LAST) ? '0 : div + 1'b1;
            if (tick) begin
                if (h_cnt == H_LAST) begin
                    h_cnt <= '0;
                    if (v_cnt == V_LAST) begin
                        v_cnt  <= '0;
                        // mode only changes across the frame wrap, never mid-frame
                        mode_q <= mode;
                    end else begin
                        v_cnt <= v_cnt + 1'b1;
                    end
                end else begin
                    h_cnt <= h_cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        h_act           = int'(h_cnt) < H_ACTIVE;
        v_act           = int'(v_cnt) < V_ACTIVE;
        head            = '0;
        head.act        = h_act && v_act;
        head.hs         = (int'(h_cnt) >= HS_BEG) && (int'(h_cnt) < HS_END);
        head.vs         = (int'(v_cnt) >= VS_BEG) && (int'(v_cnt) < VS_END);
        head.first_pix  = (h_cnt == '0) && (v_cnt == '0);
        head.first_line = (h_cnt == '0) && v_act;
        head.mode       = mode_q;
        head.h          = h_cnt;
        head.v          = v_cnt;
    end

    // Stage 0 also drives the memory address; later stages wait out RD_LAT.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k <= RD_LAT; k++) begin
                pipe[k] <= '0;
            end
            h_addr     <= '0;
            v_addr     <= '0;
            addr_valid <= 1'b0;
        end else if (tick) begin
            pipe[0] <= head;
            for (int unsigned k = 1; k <= RD_LAT; k++) begin
                pipe[k] <= pipe[k-1];
            end
            h_addr     <= head.act ? h_cnt : '0;
            v_addr     <= head.act ? v_cnt : '0;
            addr_valid <= head.act;
        end
    end

    assign tail = pipe[RD_LAT];

    always_comb begin
        bar_q   = tail.h / CNT_W'(BAR_W);
        bar_idx = (bar_q > CNT_W'(7)) ? 3'd7 : bar_q[2:0];
        pix_rgb = '0;
        case (tail.mode)
            2'b00: pix_rgb = pix_data;
            2'b01: begin
                case (bar_idx)
                    3'd0:    pix_rgb = 24'hFFFFFF;
                    3'd1:    pix_rgb = 24'hFFFF00;
                    3'd2:    pix_rgb = 24'h00FFFF;
                    3'd3:    pix_rgb = 24'h00FF00;
                    3'd4:    pix_rgb = 24'hFF00FF;
                    3'd5:    pix_rgb = 24'hFF0000;
                    3'd6:    pix_rgb = 24'h0000FF;
                    default: pix_rgb = 24'h000000;
                endcase
            end
            2'b10: begin
                if (((tail.h & CNT_W'(31)) == '0) || ((tail.v & CNT_W'(31)) == '0)) begin
                    pix_rgb = 24'hFFFFFF;
                end
            end
            default: pix_rgb = solid_rgb;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid       <= 1'b0;
            hsync       <= ~HS_ON;
            vsync       <= ~VS_ON;
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            line_start  <= 1'b0;
            if (tick) begin
                valid                 <= tail.act;
                hsync                 <= tail.hs ? HS_ON : ~HS_ON;
                vsync                 <= tail.vs ? VS_ON : ~VS_ON;
                {vga_r, vga_g, vga_b} <= tail.act ? pix_rgb : '0;
                frame_start           <= tail.first_pix;
                line_start            <= tail.first_line;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two reduced-size timing modes checked every cycle
// against a position-based model, plus hand-computed literal expectations.
module tb_vga_timing_gen;

    localparam int HA = 64, HF = 4, HS = 8, HB = 4;
    localparam int VA = 12, VF = 2, VS = 2, VB = 3;
    localparam int H_TOT = HA + HF + HS + HB;   // 80
    localparam int V_TOT = VA + VF + VS + VB;   // 19
    localparam int FRAME = H_TOT * V_TOT;       // 1520
    localparam int CW = 7;
    localparam int LAT_A = 2, LAT_B = 0;
    localparam int TMO = 4 * FRAME * 2 + 200;

    localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                         24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b1;
    logic [1:0] mode = 2'b00;
    logic [23:0] solid_rgb = 24'h123456;

    logic [CW-1:0] h_addr_a, v_addr_a, h_addr_b, v_addr_b;
    logic addr_valid_a, addr_valid_b;
    logic [23:0] pix_a, pix_b;
    logic hsync_a, vsync_a, valid_a, frame_start_a, line_start_a;
    logic hsync_b, vsync_b, valid_b, frame_start_b, line_start_b;
    logic [7:0] r_a, g_a, b_a, r_b, g_b, b_b;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    bit chk_on = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(0), .VS_POL(0), .PIX_DIV(1), .RD_LAT(LAT_A), .CNT_W(CW)
    ) dut_a (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .solid_rgb(solid_rgb),
        .h_addr(h_addr_a), .v_addr(v_addr_a), .addr_valid(addr_valid_a),
        .pix_data(pix_a), .hsync(hsync_a), .vsync(vsync_a), .valid(valid_a),
        .vga_r(r_a), .vga_g(g_a), .vga_b(b_a),
        .frame_start(frame_start_a), .line_start(line_start_a)
    );

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1), .VS_POL(1), .PIX_DIV(2), .RD_LAT(LAT_B), .CNT_W(CW)
    ) dut_b (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .solid_rgb(solid_rgb),
        .h_addr(h_addr_b), .v_addr(v_addr_b), .addr_valid(addr_valid_b),
        .pix_data(pix_b), .hsync(hsync_b), .vsync(vsync_b), .valid(valid_b),
        .vga_r(r_b), .vga_g(g_b), .vga_b(b_b),
        .frame_start(frame_start_b), .line_start(line_start_b)
    );

    // Pixel ticks as seen from the outside: A ticks every enabled clk, B every 2nd.
    logic bdiv_b = 1'b0;
    logic tick_a, tick_b;
    assign tick_a = en;
    assign tick_b = en && bdiv_b;
    always @(posedge clk) begin
        if (rst) bdiv_b <= 1'b0;
        else if (en) bdiv_b <= ~bdiv_b;
    end

    function automatic logic [23:0] memf(input logic [CW-1:0] h, input logic [CW-1:0] v);
        return {8'(h), 8'(v), 8'h5A};
    endfunction

    // Memory with 2 ticks of latency for A, combinational for B.
    logic [23:0] m1, m2;
    always @(posedge clk) begin
        if (tick_a) begin
            m1 <= memf(h_addr_a, v_addr_a);
            m2 <= m1;
        end
    end
    assign pix_a = m2;
    assign pix_b = memf(h_addr_b, v_addr_b);

    // Model state: ticks since reset, whether the last edge was a tick, frame modes.
    int ta = 0, tb = 0;
    bit ka = 0, kb = 0;
    logic [23:0] sol_a = '0, sol_b = '0;
    logic [1:0] fm_a [int];
    logic [1:0] fm_b [int];

    always @(posedge clk) begin
        if (rst) begin
            ta = 0; tb = 0; ka = 0; kb = 0;
            fm_a.delete(); fm_b.delete();
            fm_a[0] = 2'b00; fm_b[0] = 2'b00;
        end else begin
            ka = tick_a;
            kb = tick_b;
            if (tick_a) begin
                ta++;
                sol_a = solid_rgb;
                if (ta % FRAME == 0) fm_a[ta / FRAME] = mode;
            end
            if (tick_b) begin
                tb++;
                sol_b = solid_rgb;
                if (tb % FRAME == 0) fm_b[tb / FRAME] = mode;
            end
        end
    end

    // After t ticks the address stage shows position t-1, the outputs position t-lat-2.
    function automatic logic [43:0] model(input int t, input bit k, input int lat,
                                          input logic hp, input logic vp,
                                          input logic [1:0] fm, input logic [23:0] sol);
        int p, h, v, bi;
        logic [CW-1:0] ha, va;
        logic av, vld, hs, vs, fs, ls;
        logic [23:0] rgb;
        ha = '0; va = '0; av = 1'b0;
        vld = 1'b0; hs = ~hp; vs = ~vp; fs = 1'b0; ls = 1'b0; rgb = '0;
        if (t >= 1) begin
            p = t - 1;
            h = p % H_TOT;
            v = (p / H_TOT) % V_TOT;
            av = (h < HA) && (v < VA);
            if (av) begin ha = CW'(h); va = CW'(v); end
        end
        if (t >= lat + 2) begin
            p = t - lat - 2;
            h = p % H_TOT;
            v = (p / H_TOT) % V_TOT;
            vld = (h < HA) && (v < VA);
            hs = (h >= HA + HF && h < HA + HF + HS) ? hp : ~hp;
            vs = (v >= VA + VF && v < VA + VF + VS) ? vp : ~vp;
            fs = k && h == 0 && v == 0;
            ls = k && h == 0 && v < VA;
            if (vld) begin
                bi = h / (HA / 8);
                if (bi > 7) bi = 7;
                case (fm)
                    2'b00: rgb = {8'(h), 8'(v), 8'h5A};
                    2'b01: rgb = BARS[bi];
                    2'b10: rgb = (h % 32 == 0 || v % 32 == 0) ? 24'hFFFFFF : 24'h000000;
                    default: rgb = sol;
                endcase
            end
        end
        return {vld, hs, vs, fs, ls, rgb, av, ha, va};
    endfunction

    function automatic logic [1:0] frame_mode_a(input int t);
        int fr;
        fr = (t >= LAT_A + 2) ? (t - LAT_A - 2) / FRAME : 0;
        return fm_a.exists(fr) ? fm_a[fr] : 2'b00;
    endfunction

    function automatic logic [1:0] frame_mode_b(input int t);
        int fr;
        fr = (t >= LAT_B + 2) ? (t - LAT_B - 2) / FRAME : 0;
        return fm_b.exists(fr) ? fm_b[fr] : 2'b00;
    endfunction

    logic [43:0] act_a, act_b;
    assign act_a = {valid_a, hsync_a, vsync_a, frame_start_a, line_start_a,
                    r_a, g_a, b_a, addr_valid_a, h_addr_a, v_addr_a};
    assign act_b = {valid_b, hsync_b, vsync_b, frame_start_b, line_start_b,
                    r_b, g_b, b_b, addr_valid_b, h_addr_b, v_addr_b};

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
            if (n_err >= 200) begin
                $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
                $finish;
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("model_a", act_a, model(ta, ka, LAT_A, 1'b0, 1'b0, frame_mode_a(ta), sol_a));
            check("model_b", act_b, model(tb, kb, LAT_B, 1'b1, 1'b1, frame_mode_b(tb), sol_b));
        end
    end

    function automatic bit sig(input int sel);
        case (sel)
            0: return frame_start_a;
            1: return line_start_a;
            2: return frame_start_b;
            3: return line_start_b;
            4: return !vsync_a;
            5: return hsync_b;
            default: return !hsync_a;
        endcase
    endfunction

    task automatic wait_for(input string nm, input int sel);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sig(sel) && n < TMO);
        if (!sig(sel)) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: no event within %0d cycles, expected one", nm, TMO);
        end
    endtask

    task automatic count_high(input int sel, output int n);
        n = 0;
        while (sig(sel) && n < TMO) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic release_and_time_first_frame(input string tag);
        int na, nb;
        na = 0; nb = 0;
        rst = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (frame_start_a && na == 0) na = n;
            if (frame_start_b && nb == 0) nb = n;
        end
        check({tag, "_first_fs_a"}, na, 4);
        check({tag, "_first_fs_b"}, nb, 4);
    endtask

    logic [23:0] rgb_a;
    assign rgb_a = {r_a, g_a, b_a};

    initial begin
        int n, c0;
        logic [43:0] snap;
        repeat (3) @(negedge clk);
        chk_on = 1;
        check("rst_hsync_a", hsync_a, 1);
        check("rst_vsync_b", vsync_b, 0);
        check("rst_valid_a", valid_a, 0);
        release_and_time_first_frame("boot");

        // Horizontal/vertical timing on A (one clk per pixel).
        wait_for("ls_a", 1);
        c0 = cyc;
        n = 0;
        while (hsync_a && n < TMO) begin n++; @(negedge clk); end
        check("valid_to_hsync_a", n, HA + HF);
        count_high(6, n);
        check("hsync_width_a", n, HS);
        wait_for("ls_a", 1);
        check("line_len_a", cyc - c0, H_TOT);
        wait_for("vsync_a", 4);
        count_high(4, n);
        check("vsync_width_a", n, VS * H_TOT);

        // B: two clks per pixel, active-high sync.
        wait_for("fs_b", 2);
        c0 = cyc;
        wait_for("fs_b", 2);
        check("frame_len_b", cyc - c0, 2 * FRAME);
        wait_for("hsync_b", 5);
        count_high(5, n);
        check("hsync_width_b", n, 2 * HS);
        wait_for("ls_b", 3);
        c0 = cyc;
        wait_for("ls_b", 3);
        check("line_len_b", cyc - c0, 2 * H_TOT);

        // Colour bars, then a mid-frame switch that must wait for the next frame.
        wait_for("fs_a", 0);
        mode = 2'b01;
        wait_for("fs_a", 0);
        check("bar_px0", rgb_a, 24'hFFFFFF);
        repeat (7) @(negedge clk);
        check("bar_px7", rgb_a, 24'hFFFFFF);
        @(negedge clk);
        check("bar_px8", rgb_a, 24'hFFFF00);
        repeat (55) @(negedge clk);
        check("bar_px63", rgb_a, 24'h000000);
        repeat (5) wait_for("ls_a", 1);
        mode = 2'b11;
        repeat (3) wait_for("ls_a", 1);
        check("bar_held_line8", rgb_a, 24'hFFFFFF);
        wait_for("fs_a", 0);
        check("solid_next_frame", rgb_a, 24'h123456);
        repeat (10) @(negedge clk);
        solid_rgb = 24'hABCDEF;
        @(negedge clk);
        check("solid_live", rgb_a, 24'hABCDEF);

        mode = 2'b10;
        wait_for("fs_a", 0);
        check("grid_0_0", rgb_a, 24'hFFFFFF);
        @(negedge clk);
        check("grid_1_0", rgb_a, 24'hFFFFFF);
        wait_for("ls_a", 1);
        @(negedge clk);
        check("grid_1_1", rgb_a, 24'h000000);

        mode = 2'b00;
        wait_for("fs_a", 0);
        check("mem_0_0", rgb_a, 24'h00005A);
        repeat (5) @(negedge clk);
        check("mem_5_0", rgb_a, 24'h05005A);

        // Pause mid-line: everything holds, markers stay low.
        wait_for("ls_a", 1);
        repeat (10) @(negedge clk);
        en = 1'b0;
        snap = act_a;
        snap[40:39] = 2'b00;
        for (int i = 0; i < 37; i++) begin
            @(negedge clk);
            if (i == 0 || i == 36) check("frozen_a", act_a, snap);
        end
        en = 1'b1;

        // Reset in the middle of active line 5, column 30.
        n = 0;
        do begin @(negedge clk); n++; end while ((ta % FRAME) != 5 * H_TOT + 30 && n < TMO);
        check("reached_h30_v5", ta % FRAME, 5 * H_TOT + 30);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_valid_a", valid_a, 0);
        check("mid_rst_addr_valid_a", addr_valid_a, 0);
        check("mid_rst_hsync_a", hsync_a, 1);
        check("mid_rst_rgb_a", rgb_a, 24'h000000);
        @(negedge clk);
        release_and_time_first_frame("mid");

        wait_for("fs_b", 2);
        wait_for("fs_b", 2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
